// File: rtl/div_8bit.sv
// Sequential unsigned restoring divider: 8-bit dividend / 5-bit divisor, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor into an immediate flagged result.
module div_8bit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] dividend_i,
  input  logic [4:0] divisor_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [7:0] quotient_o,
  output logic [4:0] remainder_o,
  output logic       div0_o
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t state;
  state_t state_next;

  logic [7:0] dividend_sr;
  logic [4:0] divisor_r;
  logic [5:0] rem_r;
  logic [7:0] quo_sr;
  logic [2:0] count;

  logic accept;
  logic step;
  logic finish;
`ifdef DIV_ZERO_DETECT_EN
  logic zero_accept;
`endif

  logic [5:0] rem_shift;
  logic [6:0] trial;
  logic       q_bit;
  logic [5:0] rem_next;
  logic [7:0] quo_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    accept = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zero_accept = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef DIV_ZERO_DETECT_EN
        if (start_i && divisor_i == 5'd0) begin
          zero_accept = 1'b1;
        end else begin
          accept = start_i;
        end
`else
        accept = start_i;
`endif
      end
      CALC: begin
        busy_o = 1'b1;
        step   = 1'b1;
        finish = (count == 3'd7);
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // One restoring step: a negative 7-bit trial difference means the divisor did not fit.
  always_comb begin
    rem_shift = {rem_r[4:0], dividend_sr[7]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor_r};
    q_bit     = ~trial[6];
    rem_next  = q_bit ? trial[5:0] : rem_shift;
    quo_next  = {quo_sr[6:0], q_bit};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dividend_sr <= 8'h00;
      divisor_r   <= 5'h00;
      rem_r       <= 6'h00;
      quo_sr      <= 8'h00;
      count       <= 3'd0;
      valid_o     <= 1'b0;
      quotient_o  <= 8'h00;
      remainder_o <= 5'h00;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        dividend_sr <= dividend_i;
        divisor_r   <= divisor_i;
        rem_r       <= 6'h00;
        quo_sr      <= 8'h00;
        count       <= 3'd0;
      end
      if (step) begin
        dividend_sr <= {dividend_sr[6:0], 1'b0};
        rem_r       <= rem_next;
        quo_sr      <= quo_next;
        count       <= count + 3'd1;
      end
      if (finish) begin
        quotient_o  <= quo_next;
        remainder_o <= rem_next[4:0];
        valid_o     <= 1'b1;
      end
`ifdef DIV_ZERO_DETECT_EN
      if (zero_accept) begin
        quotient_o  <= 8'hFF;
        remainder_o <= dividend_i[4:0];
        valid_o     <= 1'b1;
      end
`endif
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // The flag is held with the result and only changes when a new result is produced.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div0_o <= 1'b0;
    end else if (zero_accept) begin
      div0_o <= 1'b1;
    end else if (finish) begin
      div0_o <= 1'b0;
    end
  end
`else
  assign div0_o = 1'b0;
`endif

endmodule
